// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status codes, control numbers, the decoded message
// record and helpers used by both the MIDI decoder and encoder.
package midi_pkg;

    typedef enum logic [3:0] {
        NoteOff       = 4'h8,
        NoteOn        = 4'h9,
        ControlChange = 4'hB
    } status_t;

    localparam logic [6:0] CcModWheel = 7'd1;
    localparam logic [6:0] CcVolume   = 7'd7;
    localparam logic [6:0] CcPan      = 7'd10;
    localparam logic [6:0] CcSustain  = 7'd64;

    typedef struct packed {
        logic [3:0] status;
        logic [3:0] channel;
        logic [6:0] data1;
        logic [6:0] data2;
    } message_t;

    function automatic logic is_supported(input status_t s);
        case (s)
            NoteOff, NoteOn, ControlChange: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] status_byte(input message_t m);
        return {m.status, m.channel};
    endfunction

endpackage

// File: rtl/midi_running_status.sv
// Running-status tracker: remembers the last status byte sent and how long ago,
// so a repeated status can be omitted while the receiver still remembers it.
module midi_running_status
    import midi_pkg::*;
#(
    parameter int unsigned RS_REFRESH_CYCLES = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       status_xfer_i,
    input  logic [7:0] status_byte_i,
    input  logic [7:0] query_byte_i,
    output logic       hit_o
);

    localparam int unsigned CntW = $clog2(RS_REFRESH_CYCLES + 1) < 1 ? 1 :
                                   $clog2(RS_REFRESH_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(RS_REFRESH_CYCLES);

    logic [7:0]      last_status_q, last_status_d;
    logic            rs_valid_q, rs_valid_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        last_status_d = last_status_q;
        rs_valid_d    = rs_valid_q;
        cnt_d         = cnt_q;
        if (status_xfer_i) begin
            last_status_d = status_byte_i;
            rs_valid_d    = 1'b1;
            cnt_d         = '0;
        end else begin
            // Saturate so a long silence never wraps back into a "fresh" window.
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CntMax) begin
                rs_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_status_q <= 8'h00;
            rs_valid_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            last_status_q <= last_status_d;
            rs_valid_q    <= rs_valid_d;
            cnt_q         <= cnt_d;
        end
    end

    assign hit_o = rs_valid_q && (last_status_q == query_byte_i);

endmodule

// File: rtl/midi_encoder.sv
// Serialises one decoded MIDI message into status/data1/data2 bytes over a
// valid/ready byte stream. Optional running status: define MIDI_RUNNING_STATUS_EN.
module midi_encoder
    import midi_pkg::*;
#(
    parameter int unsigned RS_REFRESH_CYCLES = 50_000_000
) (
    input  logic                   clock_50_000_000,
    input  logic                   reset_l,
    input  logic [$bits(message_t)-1:0] message,
    input  logic                   message_valid,
    output logic                   message_ready,
    output logic [7:0]             data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   message_dropped
);

    typedef enum logic [1:0] {
        StIdle,
        StStatus,
        StData1,
        StData2
    } state_t;

    state_t   state_q, state_d;
    message_t msg_q, msg_d;
    message_t msg_in;
    logic     drop_q, drop_d;
    logic     accept;
    logic     supported;
    logic     rs_hit;

    assign msg_in        = message_t'(message);
    assign message_ready = (state_q == StIdle);
    assign accept        = message_valid && message_ready;
    assign supported     = is_supported(status_t'(msg_in.status));

`ifdef MIDI_RUNNING_STATUS_EN
    logic status_xfer;

    assign status_xfer = (state_q == StStatus) && data_out_ready;

    midi_running_status #(
        .RS_REFRESH_CYCLES (RS_REFRESH_CYCLES)
    ) u_running_status (
        .clk_i         (clock_50_000_000),
        .rst_ni        (reset_l),
        .status_xfer_i (status_xfer),
        .status_byte_i (status_byte(msg_q)),
        .query_byte_i  (status_byte(msg_in)),
        .hit_o         (rs_hit)
    );
`else
    logic unused_rs_cfg;

    assign unused_rs_cfg = ^RS_REFRESH_CYCLES;
    assign rs_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        drop_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    msg_d = msg_in;
                    if (!supported) begin
                        drop_d = 1'b1;
                    end else if (rs_hit) begin
                        state_d = StData1;
                    end else begin
                        state_d = StStatus;
                    end
                end
            end
            StStatus: if (data_out_ready) state_d = StData1;
            StData1:  if (data_out_ready) state_d = StData2;
            StData2:  if (data_out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bytes are decoded from registered state so they stay put through any stall.
    always_comb begin
        data_out       = 8'h00;
        data_out_valid = (state_q != StIdle);
        unique case (state_q)
            StStatus: data_out = status_byte(msg_q);
            StData1:  data_out = {1'b0, msg_q.data1};
            StData2:  data_out = {1'b0, msg_q.data2};
            default:  data_out = 8'h00;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= StIdle;
            msg_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            drop_q  <= drop_d;
        end
    end

    assign message_dropped = drop_q;

endmodule

// File: tb/tb_midi_encoder.sv
// Self-checking bench for midi_encoder: spec vectors, reset/running-status
// sequences and randomised messages against a byte-stream reference model.
module tb_midi_encoder;
    import midi_pkg::*;

    localparam int RS = 16;

    logic        clk;
    logic        reset_l;
    message_t    message;
    logic        message_valid;
    logic        message_ready;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        message_dropped;

    int n_checks;
    int n_fail;
    int cyc;

    // Reference model of the receiver's running-status memory.
    bit         rs_en;
    bit         rs_valid_m;
    logic [7:0] rs_last_m;
    int         rs_edge_m;

    typedef struct {
        logic [3:0] st;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
        int         stall;
        int         n;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs[7];

    midi_encoder #(
        .RS_REFRESH_CYCLES (RS)
    ) dut (
        .clock_50_000_000 (clk),
        .reset_l          (reset_l),
        .message          (message),
        .message_valid    (message_valid),
        .message_ready    (message_ready),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .data_out_ready   (data_out_ready),
        .message_dropped  (message_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driven from a negedge; leaves the bench on a negedge with the encoder idle.
    task automatic send(input logic [3:0] st, input logic [3:0] ch, input logic [6:0] d1,
                        input logic [6:0] d2, input int stall, input int n,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input string tag);
        logic [7:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        check({tag, " ready before accept"}, message_ready, 1);
        message.status  = st;
        message.channel = ch;
        message.data1   = d1;
        message.data2   = d2;
        message_valid   = 1'b1;
        data_out_ready  = (stall == 0);
        @(negedge clk);
        message_valid = 1'b0;
        if (n == 0) begin
            check({tag, " dropped pulse"}, message_dropped, 1);
            check({tag, " no byte on drop"}, data_out_valid, 0);
            check({tag, " ready stays high"}, message_ready, 1);
            @(negedge clk);
            check({tag, " dropped one cycle"}, message_dropped, 0);
            check({tag, " still no byte"}, data_out_valid, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stall; s++) begin
                check({tag, " stalled valid"}, data_out_valid, 1);
                check({tag, " stalled byte"}, data_out, e[i]);
                check({tag, " busy ready"}, message_ready, 0);
                @(negedge clk);
            end
            data_out_ready = 1'b1;
            check({tag, " byte valid"}, data_out_valid, 1);
            check({tag, " byte value"}, data_out, e[i]);
            check({tag, " busy ready"}, message_ready, 0);
            if (e[i][7]) begin
                rs_valid_m = 1'b1;
                rs_last_m  = e[i];
                rs_edge_m  = cyc + 1;
            end
            @(negedge clk);
            data_out_ready = (stall == 0);
        end
        data_out_ready = 1'b0;
        check({tag, " idle after msg"}, data_out_valid, 0);
        check({tag, " ready after msg"}, message_ready, 1);
    endtask

    // Expected byte stream for a message accepted at the next rising edge.
    task automatic model(input logic [3:0] st, input logic [3:0] ch, input logic [6:0] d1,
                         input logic [6:0] d2, output int n, output logic [7:0] e0,
                         output logic [7:0] e1, output logic [7:0] e2);
        logic [7:0] sb;
        sb = {st, ch};
        e2 = 8'h00;
        if (!(st == 4'h8 || st == 4'h9 || st == 4'hB)) begin
            n  = 0;
            e0 = 8'h00;
            e1 = 8'h00;
        end else if (rs_en && rs_valid_m && rs_last_m == sb && (cyc + 1 - rs_edge_m) <= RS) begin
            n  = 2;
            e0 = {1'b0, d1};
            e1 = {1'b0, d2};
        end else begin
            n  = 3;
            e0 = sb;
            e1 = {1'b0, d1};
            e2 = {1'b0, d2};
        end
    endtask

    initial begin
        int         n;
        logic [7:0] e0, e1, e2;
        logic [3:0] st, ch;
        logic [6:0] d1, d2;
        logic [3:0] st_pick[6];

        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        rs_valid_m = 1'b0;
        rs_last_m  = 8'h00;
        rs_edge_m  = 0;
`ifdef MIDI_RUNNING_STATUS_EN
        rs_en = 1'b1;
`else
        rs_en = 1'b0;
`endif
        st_pick = '{4'h8, 4'h9, 4'hB, 4'hC, 4'hE, 4'hA};

        vecs[0] = '{4'h9, 4'h0, 7'd10,  7'd80,  0, 3, 8'h90, 8'h0A, 8'h50};
        vecs[1] = '{4'hB, 4'h3, CcVolume, 7'd60, 5, 3, 8'hB3, 8'h07, 8'h3C};
        vecs[2] = '{4'hC, 4'h0, 7'd50,  7'd0,   0, 0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{4'h9, 4'hF, 7'd64,  7'd0,   1, 3, 8'h9F, 8'h40, 8'h00};
        vecs[4] = '{4'h8, 4'h9, 7'd127, 7'd127, 2, 3, 8'h89, 8'h7F, 8'h7F};
        vecs[5] = '{4'hE, 4'h2, 7'd1,   7'd2,   0, 0, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{4'hB, 4'h3, 7'd1,   7'd127, 0, 3, 8'hB3, 8'h01, 8'h7F};

        reset_l        = 1'b0;
        message        = '0;
        message_valid  = 1'b0;
        data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data_out_valid", data_out_valid, 0);
        check("reset data_out", data_out, 8'h00);
        check("reset message_dropped", message_dropped, 0);
        reset_l = 1'b1;
        @(negedge clk);
        check("post-reset message_ready", message_ready, 1);
        check("post-reset data_out_valid", data_out_valid, 0);

        foreach (vecs[i]) begin
            send(vecs[i].st, vecs[i].ch, vecs[i].d1, vecs[i].d2, vecs[i].stall, vecs[i].n,
                 vecs[i].e0, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Reset after the status byte of NOTE_OFF has gone out.
        check("rst-mid ready", message_ready, 1);
        message.status  = 4'h8;
        message.channel = 4'h0;
        message.data1   = 7'd30;
        message.data2   = 7'd40;
        message_valid   = 1'b1;
        data_out_ready  = 1'b1;
        @(negedge clk);
        message_valid = 1'b0;
        check("rst-mid first byte", data_out, 8'h80);
        check("rst-mid first valid", data_out_valid, 1);
        @(posedge clk);
        #1;
        reset_l = 1'b0;
        #1;
        check("rst-mid valid drops", data_out_valid, 0);
        check("rst-mid data cleared", data_out, 8'h00);
        rs_valid_m     = 1'b0;
        data_out_ready = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        check("rst-mid no resume", data_out_valid, 0);
        send(4'h8, 4'h0, 7'd30, 7'd40, 0, 3, 8'h80, 8'h1E, 8'h28, "rst-mid fresh");

        if (rs_en) begin
            send(4'h9, 4'h0, 7'd20, 7'd0, 0, 3, 8'h90, 8'h14, 8'h00, "rs first");
            send(4'h9, 4'h0, 7'd60, 7'd80, 0, 2, 8'h3C, 8'h50, 8'h00, "rs repeat");
            send(4'h8, 4'h0, 7'd30, 7'd40, 0, 3, 8'h80, 8'h1E, 8'h28, "rs new status");
            send(4'h9, 4'h0, 7'd1, 7'd2, 0, 3, 8'h90, 8'h01, 8'h02, "rs prime");
            send(4'hC, 4'h0, 7'd5, 7'd0, 0, 0, 8'h00, 8'h00, 8'h00, "rs drop");
            send(4'h9, 4'h0, 7'd3, 7'd4, 1, 2, 8'h03, 8'h04, 8'h00, "rs after drop");
            repeat (20) @(negedge clk);
            send(4'h9, 4'h0, 7'd5, 7'd6, 0, 3, 8'h90, 8'h05, 8'h06, "rs expired");
        end

        for (int k = 0; k < 40; k++) begin
            st = st_pick[$urandom_range(0, 5)];
            ch = 4'($urandom_range(0, 1));
            d1 = 7'($urandom);
            d2 = 7'($urandom);
            model(st, ch, d1, d2, n, e0, e1, e2);
            send(st, ch, d1, d2, $urandom_range(0, 2), n, e0, e1, e2,
                 $sformatf("rand%0d", k));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
